// File: rtl/key_event_queue.sv
// Key event queue: synchronises and debounces the keypad scanner's level-type
// key code and queues exactly one event per press in a 4-entry show-ahead FIFO.
module key_event_queue #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 8
) (
  input  logic       in_clk,
  input  logic       reset,
  input  logic [3:0] scan_value,
  input  logic       scan_enable,
  input  logic       key_ready,
  input  logic       overflow_clr,
  output logic       key_valid,
  output logic [3:0] key_data,
  output logic [2:0] fifo_count,
  output logic       key_held,
  output logic       overflow
);

  localparam int unsigned KEY_W   = 4;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned PTR_W   = 2;
  localparam int unsigned COUNT_W = 3;

  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] FULL     = COUNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_DEB   = 2'd1,
    HELD        = 2'd2,
    RELEASE_DEB = 2'd3
  } state_t;

  logic [KEY_W-1:0] val_s1, val_s;
  logic             en_s1, en_s;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [KEY_W-1:0] cap;

  logic [DEPTH-1:0][KEY_W-1:0] mem;
  logic [PTR_W-1:0]            rd_ptr, wr_ptr;
  logic [COUNT_W-1:0]          count;

  logic push_c, pop_c, wr_en_c, drop_c;

  // Two-flop synchroniser for the scanner-domain code and enable
  always_ff @(posedge in_clk or negedge reset) begin
    if (!reset) begin
      val_s1 <= '0;
      val_s  <= '0;
      en_s1  <= 1'b0;
      en_s   <= 1'b0;
    end else begin
      val_s1 <= scan_value;
      val_s  <= val_s1;
      en_s1  <= scan_enable;
      en_s   <= en_s1;
    end
  end

  // A press is accepted on the last stable cycle of the press debounce window
  assign push_c = (state == PRESS_DEB) && en_s && (val_s == cap) && (cnt == CNT_LAST);

  // Press/release debounce FSM
  always_ff @(posedge in_clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      cap   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en_s) begin
            state <= PRESS_DEB;
            cap   <= val_s;
            cnt   <= '0;
          end
        end
        PRESS_DEB: begin
          if (!en_s || (val_s != cap)) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            state <= HELD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HELD: begin
          if (!en_s) begin
            state <= RELEASE_DEB;
            cnt   <= '0;
          end
        end
        RELEASE_DEB: begin
          if (en_s) begin
            state <= HELD;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // When full, a push only fits if the head leaves in the same cycle
  assign pop_c   = key_valid && key_ready;
  assign wr_en_c = push_c && ((count != FULL) || pop_c);
  assign drop_c  = push_c && (count == FULL) && !pop_c;

  always_ff @(posedge in_clk or negedge reset) begin
    if (!reset) begin
      mem      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en_c) begin
        mem[wr_ptr] <= cap;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_en_c, pop_c})
        2'b10:   count <= count + COUNT_W'(1);
        2'b01:   count <= count - COUNT_W'(1);
        default: count <= count;
      endcase
      if (drop_c) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  assign key_valid  = (count != '0);
  assign key_data   = key_valid ? mem[rd_ptr] : '0;
  assign fifo_count = count;
  assign key_held   = (state == HELD) || (state == RELEASE_DEB);

endmodule

// File: tb/tb_key_event_queue.sv
// Bench for key_event_queue: constant vector table, hand-written corner
// sequences and random stimulus against a run-length/queue reference model.
`timescale 1ns/1ps
module tb_key_event_queue;

  localparam int unsigned D = 4;

  logic       in_clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] scan_value = 4'd0;
  logic       scan_enable = 1'b0;
  logic       key_ready = 1'b0;
  logic       overflow_clr = 1'b0;
  logic       key_valid;
  logic [3:0] key_data;
  logic [2:0] fifo_count;
  logic       key_held;
  logic       overflow;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 in_clk = ~in_clk;

  key_event_queue #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
    .in_clk(in_clk), .reset(reset), .scan_value(scan_value), .scan_enable(scan_enable),
    .key_ready(key_ready), .overflow_clr(overflow_clr), .key_valid(key_valid),
    .key_data(key_data), .fifo_count(fifo_count), .key_held(key_held), .overflow(overflow)
  );

  // Reference model: 2-sample delay line, run-length debounce, queue FIFO
  typedef struct packed { logic en; logic [3:0] val; } smp_t;
  smp_t pipe[$];
  int   m_q[$];
  bit   m_pressed, m_ovf;
  int   m_run, m_runval, m_rel;

  task automatic model_reset();
    smp_t z;
    z = '0;
    pipe = {};
    pipe.push_back(z);
    pipe.push_back(z);
    m_q = {};
    m_pressed = 0; m_ovf = 0; m_run = 0; m_runval = 0; m_rel = 0;
  endtask

  task automatic model_edge(input bit en, input logic [3:0] val, input bit rdy, input bit clr);
    smp_t s, n;
    bit push, pop, drop;
    s = pipe.pop_front();
    n.en = en; n.val = val;
    pipe.push_back(n);
    push = 0; drop = 0;
    if (m_pressed) begin
      if (!s.en) begin
        m_rel++;
        if (m_rel == D + 1) begin m_pressed = 0; m_rel = 0; end
      end else m_rel = 0;
    end else if (m_run == 0) begin
      if (s.en) begin m_run = 1; m_runval = int'(s.val); end
    end else if (s.en && int'(s.val) == m_runval) begin
      m_run++;
      if (m_run == D + 1) begin push = 1; m_pressed = 1; m_run = 0; end
    end else m_run = 0;
    pop = (m_q.size() != 0) && rdy;
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < 4) m_q.push_back(m_runval);
      else drop = 1;
    end
    if (drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
  endtask

  task automatic check_out(input string name, input bit ev, input logic [3:0] ed,
                           input logic [2:0] ec, input bit eh, input bit eo);
    n_cmp++;
    if ({key_valid, key_data, fifo_count, key_held, overflow} !== {ev, ed, ec, eh, eo}) begin
      n_bad++;
      $display("FAIL %s: got valid=%0b data=%0d count=%0d held=%0b ovf=%0b, expected valid=%0b data=%0d count=%0d held=%0b ovf=%0b",
               name, key_valid, key_data, fifo_count, key_held, overflow, ev, ed, ec, eh, eo);
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_model(input string name);
    logic [3:0] hd;
    hd = (m_q.size() != 0) ? 4'(m_q[0]) : 4'd0;
    check_out(name, m_q.size() != 0, hd, 3'(m_q.size()), m_pressed, m_ovf);
  endtask

  task automatic step(input string name);
    @(posedge in_clk);
    model_edge(scan_enable, scan_value, key_ready, overflow_clr);
    #1;
    check_model(name);
  endtask

  task automatic set_in(input bit en, input logic [3:0] v, input bit rdy, input bit clr);
    scan_enable = en; scan_value = v; key_ready = rdy; overflow_clr = clr;
  endtask

  // Hold a key long enough to be accepted, optionally popping on the push edge, then release
  task automatic press(input logic [3:0] v, input bit rdy_at_push);
    set_in(1, v, 0, 0);
    repeat (D + 2) step("press");
    key_ready = rdy_at_push;
    step("press_edge");
    key_ready = 0;
    scan_enable = 0;
    repeat (D + 3) step("release");
  endtask

  task automatic pop_expect(input string name, input int d);
    check_val({name, "_valid"}, int'(key_valid), 1);
    check_val({name, "_data"}, int'(key_data), d);
    key_ready = 1;
    step(name);
    key_ready = 0;
  endtask

  typedef struct {
    bit en; logic [3:0] val; bit rdy; int n;
    bit ev; logic [3:0] ed; logic [2:0] ec; bit eh; bit eo;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit en, input logic [3:0] val, input bit rdy, input int n,
                     input bit ev, input logic [3:0] ed, input logic [2:0] ec, input bit eh, input bit eo);
    vec_t r;
    r.en = en; r.val = val; r.rdy = rdy; r.n = n;
    r.ev = ev; r.ed = ed; r.ec = ec; r.eh = eh; r.eo = eo;
    tbl.push_back(r);
  endtask

  initial begin
    int keys4[4];
    int keys5[4];
    model_reset();
    repeat (3) @(posedge in_clk);
    #1 check_out("reset_state", 0, 0, 0, 0, 0);
    @(negedge in_clk) reset = 1;

    // Press latency, hold, release, bounces, value restart, re-press
    add(0, 0, 0,   3, 0, 0, 0, 0, 0);
    add(1, 7, 0,   6, 0, 0, 0, 0, 0);
    add(1, 7, 0,   1, 1, 7, 1, 1, 0);
    add(1, 7, 0, 100, 1, 7, 1, 1, 0);
    add(0, 7, 1,   6, 0, 0, 0, 1, 0);
    add(0, 7, 1,   1, 0, 0, 0, 0, 0);
    add(1, 2, 0,   3, 0, 0, 0, 0, 0);
    add(0, 2, 0,   1, 0, 0, 0, 0, 0);
    add(1, 2, 0,   6, 0, 0, 0, 0, 0);
    add(1, 2, 0,   1, 1, 2, 1, 1, 0);
    add(0, 2, 0,   7, 1, 2, 1, 0, 0);
    add(1, 2, 0,   3, 1, 2, 1, 0, 0);
    add(1, 5, 0,   7, 1, 2, 1, 0, 0);
    add(1, 5, 0,   1, 1, 2, 2, 1, 0);
    add(1, 5, 1,   1, 1, 5, 1, 1, 0);
    add(1, 5, 1,   1, 0, 0, 0, 1, 0);
    add(0, 5, 0,   2, 0, 0, 0, 1, 0);
    add(1, 5, 0,   4, 0, 0, 0, 1, 0);
    add(1, 5, 0,  10, 0, 0, 0, 1, 0);
    add(0, 5, 0,   6, 0, 0, 0, 1, 0);
    add(0, 5, 0,   1, 0, 0, 0, 0, 0);
    add(1, 5, 0,   6, 0, 0, 0, 0, 0);
    add(1, 5, 0,   1, 1, 5, 1, 1, 0);
    add(0, 0, 1,   7, 0, 0, 0, 0, 0);
    foreach (tbl[i]) begin
      set_in(tbl[i].en, tbl[i].val, tbl[i].rdy, 0);
      repeat (tbl[i].n) step("table_model");
      check_out($sformatf("table_row%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].ec, tbl[i].eh, tbl[i].eo);
    end
    set_in(0, 0, 0, 0);

    // Fill, overflow on a fifth press, ordered drain, overflow clear
    keys4 = '{2, 0, 7, 2};
    foreach (keys4[i]) press(4'(keys4[i]), 0);
    check_val("fill_count", int'(fifo_count), 4);
    check_val("fill_no_ovf", int'(overflow), 0);
    press(4'd9, 0);
    check_val("drop_ovf", int'(overflow), 1);
    check_val("drop_count", int'(fifo_count), 4);
    foreach (keys4[i]) pop_expect($sformatf("drain%0d", i), keys4[i]);
    check_val("empty_valid", int'(key_valid), 0);
    check_val("empty_data", int'(key_data), 0);
    check_val("ovf_sticky", int'(overflow), 1);
    overflow_clr = 1;
    step("ovf_clr");
    overflow_clr = 0;
    check_val("ovf_cleared", int'(overflow), 0);

    // Full FIFO with push and pop on the same edge; read order proves pointer wrap
    keys5 = '{1, 3, 4, 6};
    foreach (keys5[i]) press(4'(keys5[i]), 0);
    check_val("full_count", int'(fifo_count), 4);
    press(4'd8, 1);
    check_val("pushpop_count", int'(fifo_count), 4);
    check_val("pushpop_ovf", int'(overflow), 0);
    pop_expect("wrap0", 3);
    pop_expect("wrap1", 4);
    pop_expect("wrap2", 6);
    pop_expect("wrap3", 8);
    check_val("wrap_empty", int'(key_valid), 0);

    // Asynchronous reset mid-press with two entries queued
    press(4'd3, 0);
    press(4'd4, 0);
    check_val("pre_reset_count", int'(fifo_count), 2);
    set_in(1, 4'd6, 0, 0);
    repeat (4) step("press_deb");
    @(negedge in_clk);
    reset = 0;
    #1 check_out("async_reset", 0, 0, 0, 0, 0);
    @(posedge in_clk);
    @(posedge in_clk);
    #1 check_out("held_in_reset", 0, 0, 0, 0, 0);
    @(negedge in_clk);
    reset = 1;
    model_reset();
    repeat (D + 2) step("post_reset");
    check_val("post_reset_no_push", int'(fifo_count), 0);
    step("post_reset_push");
    check_val("post_reset_count", int'(fifo_count), 1);
    check_val("post_reset_data", int'(key_data), 6);
    repeat (20) step("post_reset_hold");
    check_val("post_reset_single", int'(fifo_count), 1);
    set_in(0, 0, 1, 0);
    repeat (D + 3) step("drain");

    // Random scanner activity, consumer and clear against the model
    for (int seg = 0; seg < 300; seg++) begin
      int len;
      len = $urandom_range(1, 12);
      scan_enable = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) scan_value = 4'($urandom_range(0, 11));
      for (int k = 0; k < len; k++) begin
        key_ready = ($urandom_range(0, 5) == 0);
        overflow_clr = ($urandom_range(0, 15) == 0);
        step("random");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
